// File: rtl/alu_pkg.sv
// Shared types for the sequenced ALU: opcodes, FSM states, latency classes and completion kinds.
// Op 14 is only a legal (iterative) op when ALU_DIV_EN is defined.
package alu_pkg;

    localparam int ALU_W_DEFAULT = 8;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_ADC = 4'd1,
        OP_SUB = 4'd2,
        OP_SBB = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_CMP = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9,
        OP_SAR = 4'd10,
        OP_ROL = 4'd11,
        OP_ROR = 4'd12,
        OP_MUL = 4'd13,
        OP_DIV = 4'd14,
        OP_ILL = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Latency class: zero steps, count steps, or WIDTH steps.
    typedef enum logic [1:0] {LAT_ZERO, LAT_COUNT, LAT_WIDTH, LAT_ILLEGAL} lat_t;

    // What the DONE cycle publishes.
    typedef enum logic [1:0] {FIN_FLAGS, FIN_PASS, FIN_ILLEGAL, FIN_DIVERR} fin_t;

    function automatic lat_t op_lat(alu_op_t op);
        lat_t l;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBB,
            OP_AND, OP_OR, OP_XOR, OP_CMP:        l = LAT_ZERO;
            OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: l = LAT_COUNT;
            OP_MUL:                               l = LAT_WIDTH;
`ifdef ALU_DIV_EN
            OP_DIV:                               l = LAT_WIDTH;
`endif
            default:                              l = LAT_ILLEGAL;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/alu_seq_unit_addsub.sv
// Single-cycle arithmetic/logic core for ops 0-7: result plus carry (borrow) and signed overflow.
module alu_addsub_logic
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W_DEFAULT
) (
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] dif;
    logic           ci;
    logic           bi;

    always_comb begin
        ci       = (op == OP_ADC) & cin;
        bi       = (op == OP_SBB) & cin;
        sum      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
        dif      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bi};
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                result   = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            // Bit WIDTH of the widened difference is the borrow.
            OP_SUB, OP_SBB, OP_CMP: begin
                result   = dif[WIDTH-1:0];
                carry    = dif[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Sequenced ALU feeding the flags register: one-cycle add/logic, iterative shift/rotate and multiply.
// Optional restoring divide on op 14 is enabled by defining ALU_DIV_EN.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W_DEFAULT,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] alu_result_hi,
    output logic             carry_out,
    output logic             overflow_out,
    output logic             update_flags,
    output logic             illegal_op,
    output logic             div_error
);

    localparam int STEP_W = (CNT_W > $clog2(WIDTH + 1)) ? CNT_W : $clog2(WIDTH + 1);

    state_t            state, state_nx;
    alu_op_t           op_in, op_q;
    fin_t              fin_in, fin_q;
    logic [STEP_W-1:0] steps_in, step_q;
    logic              accept;

    logic [WIDTH-1:0]  lo_q, hi_q, opnd_q;
    logic              c_q, v_q, a_msb_q, one_q;
    logic [WIDTH-1:0]  lo_step, hi_step;
    logic              c_step, c_fin, v_fin;
    logic [WIDTH:0]    wide;

    logic [WIDTH-1:0]  as_res;
    logic              as_c, as_v;

    assign op_in  = alu_op_t'(op);
    assign accept = (state == IDLE) && start;

    alu_addsub_logic #(.WIDTH(WIDTH)) u_addsub (
        .op       (op_in),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .result   (as_res),
        .carry    (as_c),
        .overflow (as_v)
    );

    always_comb begin
        steps_in = '0;
        fin_in   = FIN_FLAGS;
        case (op_lat(op_in))
            LAT_ZERO:  steps_in = '0;
            LAT_COUNT: begin
                steps_in = STEP_W'(count);
                if (count == '0) fin_in = FIN_PASS;
            end
            LAT_WIDTH: begin
                steps_in = STEP_W'(WIDTH);
`ifdef ALU_DIV_EN
                if (op_in == OP_DIV && b == '0) begin
                    steps_in = '0;
                    fin_in   = FIN_DIVERR;
                end
`endif
            end
            default:   fin_in = FIN_ILLEGAL;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (steps_in == '0) ? DONE : RUN;
            RUN:     if (step_q == STEP_W'(1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            step_q <= '0;
            op_q   <= OP_ADD;
            fin_q  <= FIN_FLAGS;
        end else begin
            state <= state_nx;
            if (accept) begin
                step_q <= steps_in;
                op_q   <= op_in;
                fin_q  <= fin_in;
            end else if (state == RUN) begin
                step_q <= step_q - STEP_W'(1);
            end
        end
    end

    // One iteration: shift/rotate one bit, one shift-add, or one restoring-divide step.
    always_comb begin
        lo_step = lo_q;
        hi_step = hi_q;
        c_step  = c_q;
        wide    = '0;
        case (op_q)
            OP_SHL: begin c_step = lo_q[WIDTH-1]; lo_step = {lo_q[WIDTH-2:0], 1'b0};          end
            OP_SHR: begin c_step = lo_q[0];       lo_step = {1'b0, lo_q[WIDTH-1:1]};          end
            OP_SAR: begin c_step = lo_q[0];       lo_step = {lo_q[WIDTH-1], lo_q[WIDTH-1:1]}; end
            OP_ROL: begin c_step = lo_q[WIDTH-1]; lo_step = {lo_q[WIDTH-2:0], lo_q[WIDTH-1]}; end
            OP_ROR: begin c_step = lo_q[0];       lo_step = {lo_q[0], lo_q[WIDTH-1:1]};       end
            OP_MUL: begin
                wide               = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
                {hi_step, lo_step} = {wide, lo_q[WIDTH-1:1]};
            end
`ifdef ALU_DIV_EN
            OP_DIV: begin
                wide = {hi_q, lo_q[WIDTH-1]} - {1'b0, opnd_q};
                if (!wide[WIDTH]) begin
                    hi_step = wide[WIDTH-1:0];
                    lo_step = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_step = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                    lo_step = {lo_q[WIDTH-2:0], 1'b0};
                end
            end
`endif
            default: lo_step = lo_q;
        endcase
    end

    // Working registers carry no reset: they are always loaded on accept before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            opnd_q  <= (op_in == OP_MUL) ? a : b;
            a_msb_q <= a[WIDTH-1];
            one_q   <= (count == CNT_W'(1));
            hi_q    <= '0;
            case (op_lat(op_in))
                LAT_ZERO: begin lo_q <= as_res; c_q <= as_c; v_q <= as_v; end
                default:  begin lo_q <= (op_in == OP_MUL) ? b : a; c_q <= 1'b0; v_q <= 1'b0; end
            endcase
        end else if (state == RUN) begin
            lo_q <= lo_step;
            hi_q <= hi_step;
            c_q  <= c_step;
        end
    end

    always_comb begin
        c_fin = c_q;
        v_fin = v_q;
        case (op_q)
            OP_SHL, OP_ROL: v_fin = one_q & (lo_q[WIDTH-1] ^ c_q);
            OP_SHR:         v_fin = one_q & a_msb_q;
            OP_SAR:         v_fin = 1'b0;
            OP_ROR:         v_fin = one_q & (lo_q[WIDTH-1] ^ lo_q[WIDTH-2]);
            OP_MUL:         begin c_fin = |hi_q; v_fin = |hi_q; end
            OP_DIV:         begin c_fin = 1'b0;  v_fin = 1'b0;  end
            default:        v_fin = v_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            update_flags  <= 1'b0;
            illegal_op    <= 1'b0;
            alu_result    <= '0;
            alu_result_hi <= '0;
            carry_out     <= 1'b0;
            overflow_out  <= 1'b0;
        end else begin
            busy         <= (state == RUN);
            done         <= (state == DONE);
            update_flags <= 1'b0;
            illegal_op   <= 1'b0;
            if (state == DONE) begin
                case (fin_q)
                    FIN_FLAGS: begin
                        alu_result    <= lo_q;
                        alu_result_hi <= hi_q;
                        carry_out     <= c_fin;
                        overflow_out  <= v_fin;
                        update_flags  <= 1'b1;
                    end
                    FIN_PASS: begin
                        alu_result    <= lo_q;
                        alu_result_hi <= '0;
                    end
                    FIN_ILLEGAL: illegal_op <= 1'b1;
                    default:     illegal_op <= 1'b0;
                endcase
            end
        end
    end

`ifdef ALU_DIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_error <= 1'b0;
        else        div_error <= (state == DONE) && (fin_q == FIN_DIVERR);
    end
`else
    assign div_error = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: hand-computed vectors covering latency, flags, holds and reset abort.
module tb_alu_seq_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] op = 4'd0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic       cin = 1'b0;
    logic [4:0] count = 5'd0;

    logic       busy, done, carry_out, overflow_out, update_flags, illegal_op, div_error;
    logic [7:0] alu_result, alu_result_hi;

    int total = 0;
    int bad   = 0;
    int lat;
    int bcy;
    logic seen;

    always #5 clk = ~clk;

    alu_seq_unit #(.WIDTH(8), .CNT_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .op            (op),
        .a             (a),
        .b             (b),
        .cin           (cin),
        .count         (count),
        .busy          (busy),
        .done          (done),
        .alu_result    (alu_result),
        .alu_result_hi (alu_result_hi),
        .carry_out     (carry_out),
        .overflow_out  (overflow_out),
        .update_flags  (update_flags),
        .illegal_op    (illegal_op),
        .div_error     (div_error)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, then count edges until done (bounded). poke>0 re-asserts start mid-run.
    task automatic run_op(input logic [3:0] o, input logic [7:0] aa, input logic [7:0] bb,
                          input logic c, input logic [4:0] n, input int poke);
        @(negedge clk);
        op = o; a = aa; b = bb; cin = c; count = n; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        bcy = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcy++;
            if (done) break;
            if (lat == poke) begin op = 4'd0; start = 1'b1; end
            else start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic pulse_end(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_done_drop"}, {15'd0, done}, 16'd0);
        chk({tag, "_uf_drop"}, {15'd0, update_flags}, 16'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_res", {8'd0, alu_result}, 16'd0);
        chk("rst_uf", {15'd0, update_flags}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd0, 8'h7F, 8'h01, 1'b0, 5'd0, 0);
        chk("add_lat", 16'(lat), 16'd1);
        chk("add_busy", 16'(bcy), 16'd0);
        chk("add_res", {8'd0, alu_result}, 16'h0080);
        chk("add_c", {15'd0, carry_out}, 16'd0);
        chk("add_v", {15'd0, overflow_out}, 16'd1);
        chk("add_uf", {15'd0, update_flags}, 16'd1);
        chk("add_ill", {15'd0, illegal_op}, 16'd0);
        pulse_end("add");

        run_op(4'd3, 8'h00, 8'h00, 1'b1, 5'd0, 0);
        chk("sbb_res", {8'd0, alu_result}, 16'h00FF);
        chk("sbb_c", {15'd0, carry_out}, 16'd1);
        chk("sbb_v", {15'd0, overflow_out}, 16'd0);

        run_op(4'd6, 8'hF0, 8'hFF, 1'b0, 5'd0, 0);
        chk("xor_res", {8'd0, alu_result}, 16'h000F);
        chk("xor_c", {15'd0, carry_out}, 16'd0);
        chk("xor_v", {15'd0, overflow_out}, 16'd0);

        run_op(4'd8, 8'h81, 8'h00, 1'b0, 5'd1, 0);
        chk("shl_lat", 16'(lat), 16'd2);
        chk("shl_busy", 16'(bcy), 16'd1);
        chk("shl_res", {8'd0, alu_result}, 16'h0002);
        chk("shl_c", {15'd0, carry_out}, 16'd1);
        chk("shl_v", {15'd0, overflow_out}, 16'd1);

        run_op(4'd10, 8'h80, 8'h00, 1'b0, 5'd3, 0);
        chk("sar_lat", 16'(lat), 16'd4);
        chk("sar_res", {8'd0, alu_result}, 16'h00F0);
        chk("sar_c", {15'd0, carry_out}, 16'd0);
        chk("sar_v", {15'd0, overflow_out}, 16'd0);

        run_op(4'd12, 8'h01, 8'h00, 1'b0, 5'd1, 0);
        chk("ror_res", {8'd0, alu_result}, 16'h0080);
        chk("ror_c", {15'd0, carry_out}, 16'd1);
        chk("ror_v", {15'd0, overflow_out}, 16'd1);

        run_op(4'd9, 8'h81, 8'h00, 1'b0, 5'd1, 0);
        chk("shr_res", {8'd0, alu_result}, 16'h0040);
        chk("shr_c", {15'd0, carry_out}, 16'd1);
        chk("shr_v", {15'd0, overflow_out}, 16'd1);

        run_op(4'd13, 8'h10, 8'h10, 1'b0, 5'd0, 3);
        chk("mul_lat", 16'(lat), 16'd9);
        chk("mul_busy", 16'(bcy), 16'd8);
        chk("mul_res", {8'd0, alu_result}, 16'h0000);
        chk("mul_hi", {8'd0, alu_result_hi}, 16'h0001);
        chk("mul_c", {15'd0, carry_out}, 16'd1);
        chk("mul_v", {15'd0, overflow_out}, 16'd1);
        pulse_end("mul");

        run_op(4'd9, 8'h5A, 8'h00, 1'b0, 5'd0, 0);
        chk("sh0_lat", 16'(lat), 16'd1);
        chk("sh0_uf", {15'd0, update_flags}, 16'd0);
        chk("sh0_res", {8'd0, alu_result}, 16'h005A);
        chk("sh0_hi", {8'd0, alu_result_hi}, 16'h0000);
        chk("sh0_c", {15'd0, carry_out}, 16'd1);
        chk("sh0_v", {15'd0, overflow_out}, 16'd1);

        run_op(4'd15, 8'h33, 8'h44, 1'b0, 5'd2, 0);
        chk("ill_lat", 16'(lat), 16'd1);
        chk("ill_flag", {15'd0, illegal_op}, 16'd1);
        chk("ill_uf", {15'd0, update_flags}, 16'd0);
        chk("ill_res", {8'd0, alu_result}, 16'h005A);
        chk("ill_c", {15'd0, carry_out}, 16'd1);
        pulse_end("ill");
        chk("ill_drop", {15'd0, illegal_op}, 16'd0);

`ifdef ALU_DIV_EN
        run_op(4'd14, 8'h64, 8'h07, 1'b0, 5'd0, 0);
        chk("div_lat", 16'(lat), 16'd9);
        chk("div_q", {8'd0, alu_result}, 16'h000E);
        chk("div_r", {8'd0, alu_result_hi}, 16'h0002);
        chk("div_c", {15'd0, carry_out}, 16'd0);
        run_op(4'd14, 8'h64, 8'h00, 1'b0, 5'd0, 0);
        chk("div0_lat", 16'(lat), 16'd1);
        chk("div0_err", {15'd0, div_error}, 16'd1);
        chk("div0_res", {8'd0, alu_result}, 16'h000E);
`else
        run_op(4'd14, 8'h64, 8'h07, 1'b0, 5'd0, 0);
        chk("op14_lat", 16'(lat), 16'd1);
        chk("op14_ill", {15'd0, illegal_op}, 16'd1);
        chk("op14_err", {15'd0, div_error}, 16'd0);
        chk("op14_res", {8'd0, alu_result}, 16'h005A);
`endif

        @(negedge clk);
        op = 4'd13; a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_busy_pre", {15'd0, busy}, 16'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", {15'd0, busy}, 16'd0);
        chk("abort_done", {15'd0, done}, 16'd0);
        chk("abort_uf", {15'd0, update_flags}, 16'd0);
        chk("abort_res", {8'd0, alu_result}, 16'd0);
        chk("abort_hi", {8'd0, alu_result_hi}, 16'd0);
        chk("abort_c", {15'd0, carry_out}, 16'd0);
        chk("abort_v", {15'd0, overflow_out}, 16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", {15'd0, seen}, 16'd0);

        run_op(4'd0, 8'h01, 8'h02, 1'b0, 5'd0, 0);
        chk("post_lat", 16'(lat), 16'd1);
        chk("post_res", {8'd0, alu_result}, 16'h0003);
        chk("post_uf", {15'd0, update_flags}, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
